// File: rtl/sonar_pkg.sv
// Shared constants for the sonar audio front end (PDM CIC, IIR and MAF stages).
package sonar_pkg;

  localparam int unsigned CIC_ORDER      = 4;
  localparam int unsigned CIC_DECIM_LOG2 = 6;
  localparam int unsigned PCM_W          = 16;
  localparam int unsigned CIC_ACC_W      = CIC_ORDER * CIC_DECIM_LOG2 + 2;
  // Right shift that brings the CIC gain R^N back to the PCM full-scale.
  localparam int unsigned CIC_SHIFT      = CIC_ORDER * CIC_DECIM_LOG2 - (PCM_W - 1);

endpackage

// File: rtl/pdm_sampler.sv
// PDM capture: data synchronizer, mic-clock edge detect and L/R edge select.
module pdm_sampler (
  input  logic clk,
  input  logic rst,
  input  logic edge_sel,
  input  logic mclk_i,
  input  logic pdm_i,
  output logic sample_stb,
  output logic sample_bit
);

  logic [1:0] pdm_sync;
  logic       mclk_q;
  logic       edge_c;

  // edge_sel=0 selects mclk rising edges, 1 selects falling edges.
  always_comb begin
    edge_c = 1'b0;
    if (edge_sel) edge_c = mclk_q & ~mclk_i;
    else          edge_c = mclk_i & ~mclk_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pdm_sync   <= 2'b00;
      mclk_q     <= 1'b0;
      sample_stb <= 1'b0;
      sample_bit <= 1'b0;
    end else begin
      pdm_sync   <= {pdm_sync[0], pdm_i};
      mclk_q     <= mclk_i;
      sample_stb <= edge_c;
      if (edge_c) sample_bit <= pdm_sync[1];
    end
  end

endmodule

// File: rtl/pdm_cic_decimator.sv
// PDM-to-PCM front end: edge-sampled 1-bit stream into an ORDER-stage CIC
// decimator by 2^DECIM_LOG2, scaled and saturated to signed OUT_W PCM.
module pdm_cic_decimator
  import sonar_pkg::*;
#(
  parameter int unsigned ORDER      = CIC_ORDER,
  parameter int unsigned DECIM_LOG2 = CIC_DECIM_LOG2,
  parameter int unsigned OUT_W      = PCM_W,
  parameter int unsigned ACC_W      = ORDER * DECIM_LOG2 + 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    edge_sel,
  input  logic                    mclk_i,
  input  logic                    pdm_i,
  output logic signed [OUT_W-1:0] pcm_o,
  output logic                    pcm_valid_o,
  output logic                    sat_o
);

  localparam int unsigned SHIFT = ORDER * DECIM_LOG2 - (OUT_W - 1);
  localparam logic [DECIM_LOG2-1:0] CNT_LAST  = '1;
  localparam logic [2:0]            WARM_DONE = 3'(ORDER);
  localparam logic signed [ACC_W-1:0] PCM_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] PCM_MIN = ~PCM_MAX;

  logic                    sample_stb;
  logic                    sample_bit;
  logic                    sample_en_stb;
  logic                    dec_stb;
  logic                    dec_en_stb;
  logic [DECIM_LOG2-1:0]   dec_cnt;
  logic [2:0]              warm_cnt;
  logic signed [ACC_W-1:0] x_in;
  logic signed [ACC_W-1:0] comb_out;
  logic signed [ACC_W-1:0] scaled_c;
  logic signed [OUT_W-1:0] pcm_next_c;
  logic                    clip_c;

  pdm_sampler u_sampler (
    .clk        (clk),
    .rst        (rst),
    .edge_sel   (edge_sel),
    .mclk_i     (mclk_i),
    .pdm_i      (pdm_i),
    .sample_stb (sample_stb),
    .sample_bit (sample_bit)
  );

  // Gating at the point of use drops any strobe that lands while en is low.
  assign sample_en_stb = sample_stb & en;
  assign dec_en_stb    = dec_stb & en;

  // Bit 1 -> +1, bit 0 -> -1.
  assign x_in = {{(ACC_W-1){~sample_bit}}, 1'b1};

  // Integrators wrap modulo 2^ACC_W; the combs recover the exact difference.
  for (genvar g = 0; g < ORDER; g++) begin : g_int
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] in_v;
    if (g == 0) begin : g_first
      assign in_v = x_in;
    end else begin : g_rest
      assign in_v = g_int[g-1].acc;
    end
    always_ff @(posedge clk) begin
      if (rst)                acc <= '0;
      else if (sample_en_stb) acc <= acc + in_v;
    end
  end

  for (genvar g = 0; g < ORDER; g++) begin : g_comb
    logic signed [ACC_W-1:0] x;
    logic signed [ACC_W-1:0] y;
    logic signed [ACC_W-1:0] dly;
    if (g == 0) begin : g_first
      assign x = g_int[ORDER-1].acc;
    end else begin : g_rest
      assign x = g_comb[g-1].y;
    end
    assign y = x - dly;
    always_ff @(posedge clk) begin
      if (rst)             dly <= '0;
      else if (dec_en_stb) dly <= x;
    end
  end

  assign comb_out = g_comb[ORDER-1].y;
  assign scaled_c = comb_out >>> SHIFT;

  // Clamp the scaled chain output to the signed PCM range.
  always_comb begin
    pcm_next_c = OUT_W'(scaled_c);
    clip_c     = 1'b0;
    if (scaled_c > PCM_MAX) begin
      pcm_next_c = OUT_W'(PCM_MAX);
      clip_c     = 1'b1;
    end else if (scaled_c < PCM_MIN) begin
      pcm_next_c = OUT_W'(PCM_MIN);
      clip_c     = 1'b1;
    end
  end

  // Decimation, warm-up suppression and PCM output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_cnt     <= '0;
      dec_stb     <= 1'b0;
      warm_cnt    <= 3'd0;
      pcm_o       <= '0;
      pcm_valid_o <= 1'b0;
      sat_o       <= 1'b0;
    end else begin
      dec_stb     <= sample_en_stb && (dec_cnt == CNT_LAST);
      pcm_valid_o <= 1'b0;
      if (sample_en_stb) dec_cnt <= dec_cnt + DECIM_LOG2'(1);
      if (dec_en_stb) begin
        pcm_o       <= pcm_next_c;
        pcm_valid_o <= (warm_cnt == WARM_DONE);
        if (warm_cnt != WARM_DONE) warm_cnt <= warm_cnt + 3'd1;
        if (clip_c) sat_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Directed bench for pdm_cic_decimator with mclk = clk/4 and scripted PDM patterns.
module tb_pdm_cic_decimator;

  logic clk = 1'b0;
  logic rst, en, edge_sel, mclk_i, pdm_i;
  logic signed [15:0] pcm_o;
  logic pcm_valid_o, sat_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Driver state: mic clock phase, rise count since start, PDM pattern.
  int n_rise = 0;
  int rise64_cyc = 0;
  int phase = 0;
  int pidx = 0;
  int pat_len = 4;
  logic [3:0] pat = 4'b1111;
  bit drv_on = 1'b0;
  bit toggle = 1'b0;

  int v_cyc, prev_cyc, nv;
  int held;

  pdm_cic_decimator dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .edge_sel    (edge_sel),
    .mclk_i      (mclk_i),
    .pdm_i       (pdm_i),
    .pcm_o       (pcm_o),
    .pcm_valid_o (pcm_valid_o),
    .sat_o       (sat_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Mic clock: high for 2 cycles, low for 2. Pattern bits change on the
  // falling edge; in toggle mode PDM is 1 after each rise, 0 after each fall.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!drv_on) begin
        phase  = 0;
        mclk_i = 1'b0;
        n_rise = 0;
      end else begin
        if (phase == 0) begin
          mclk_i = 1'b1;
          n_rise++;
          if (n_rise % 64 == 0) rise64_cyc = cyc;
          if (toggle) pdm_i = 1'b1;
        end else if (phase == 2) begin
          mclk_i = 1'b0;
          if (toggle) pdm_i = 1'b0;
          else begin
            pidx  = pidx % pat_len;
            pdm_i = pat[pidx];
            pidx  = (pidx + 1) % pat_len;
          end
        end
        phase = (phase + 1) % 4;
      end
    end
  end

  task automatic wait_valid(input string tag, output int at);
    bit seen;
    seen = 1'b0;
    at = -1;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (pcm_valid_o === 1'b1) begin
        seen = 1'b1;
        at = cyc;
      end
    end
    check({tag, "_seen"}, int'(seen), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drv_on = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pcm", int'(pcm_o), 0);
    check("rst_valid", int'(pcm_valid_o), 0);
    check("rst_sat", int'(sat_o), 0);
    rst = 1'b0;
    drv_on = 1'b1;
  endtask

  task automatic skip_valids(input string tag, input int n);
    int t;
    for (int i = 0; i < n; i++) wait_valid(tag, t);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; edge_sel = 1'b0; mclk_i = 1'b0; pdm_i = 1'b0;

    // All ones: first valid is the 5th decimated output, saturates high.
    pat = 4'b1111; pat_len = 4;
    do_reset();
    wait_valid("ones_first", v_cyc);
    check("ones_first_nsamp", n_rise, 320);
    check("ones_first_lat", v_cyc - rise64_cyc, 3);
    check("ones_pcm", int'(pcm_o), 32767);
    check("ones_sat", int'(sat_o), 1);
    @(negedge clk);
    check("valid_width", int'(pcm_valid_o), 0);
    prev_cyc = v_cyc;
    wait_valid("ones_next", v_cyc);
    check("valid_spacing", v_cyc - prev_cyc, 256);
    check("ones_next_lat", v_cyc - rise64_cyc, 3);
    check("ones_next_pcm", int'(pcm_o), 32767);

    // Enable gap of 100 cycles mid-frame.
    prev_cyc = v_cyc;
    held = int'(pcm_o);
    repeat (60) @(negedge clk);
    en = 1'b0;
    nv = 0;
    repeat (100) begin
      @(negedge clk);
      if (pcm_valid_o) nv++;
    end
    check("gap_valids", nv, 0);
    check("gap_hold", int'(pcm_o), held);
    en = 1'b1;
    wait_valid("gap_next", v_cyc);
    check("gap_delay", v_cyc - prev_cyc, 356);
    check("gap_pcm", int'(pcm_o), 32767);

    // Mid-frame reset, then all zeros: exact negative full scale, no clamp.
    repeat (100) @(negedge clk);
    pat = 4'b0000;
    do_reset();
    wait_valid("zeros_first", v_cyc);
    check("zeros_first_nsamp", n_rise, 320);
    check("zeros_pcm", int'(pcm_o), -32768);
    check("zeros_sat", int'(sat_o), 0);
    prev_cyc = v_cyc;
    wait_valid("zeros_next", v_cyc);
    check("zeros_spacing", v_cyc - prev_cyc, 256);
    check("zeros_next_pcm", int'(pcm_o), -32768);
    check("zeros_next_sat", int'(sat_o), 0);

    // Pattern 1,1,1,0 -> half scale.
    pat = 4'b0111; pat_len = 4;
    skip_valids("p1110_skip", 4);
    wait_valid("p1110_a", v_cyc);
    check("p1110_pcm_a", int'(pcm_o), 16384);
    wait_valid("p1110_b", v_cyc);
    check("p1110_pcm_b", int'(pcm_o), 16384);
    check("p1110_sat", int'(sat_o), 0);

    // Pattern 1,0 -> zero.
    pat = 4'b0001; pat_len = 2;
    skip_valids("p10_skip", 4);
    wait_valid("p10_a", v_cyc);
    check("p10_pcm_a", int'(pcm_o), 0);
    wait_valid("p10_b", v_cyc);
    check("p10_pcm_b", int'(pcm_o), 0);

    // PDM toggling with mclk: rising edges see 0s, falling edges see 1s.
    toggle = 1'b1;
    edge_sel = 1'b0;
    do_reset();
    wait_valid("rise_first", v_cyc);
    check("rise_nsamp", n_rise, 320);
    check("rise_pcm", int'(pcm_o), -32768);
    edge_sel = 1'b1;
    do_reset();
    wait_valid("fall_first", v_cyc);
    check("fall_pcm", int'(pcm_o), 32767);
    check("fall_sat", int'(sat_o), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pdm_cic_decimator.md
# pdm_cic_decimator

PDM-to-PCM front end for one MEMS microphone channel. It samples the 1-bit PDM stream on the selected edge of the microphone clock, then decimates it through a 4th-order CIC filter. It emits 16-bit signed PCM words with a valid strobe. It fills the currently empty PDM stage and drives the PCM input register, replacing the GPIO-sourced PCM bus.

## Interface

Parameters:
- ORDER, 4: CIC stages (integrators = combs = ORDER).
- DECIM_LOG2, 6: log2 of decimation ratio R (R = 64).
- OUT_W, 16: PCM output width.
- ACC_W, ORDER*DECIM_LOG2+2 (26): internal accumulator width.

Ports:
- clk, input, 1: system clock (Wishbone clock).
- rst, input, 1: reset; rst synchronous, active-high.
- en, input, 1: block enable (control[0]); low freezes all state.
- edge_sel, input, 1: 0 samples PDM on mclk rising edge, 1 on falling edge (L/R mic select).
- mclk_i, input, 1: microphone clock, generated in the clk domain by the mic clock divider.
- pdm_i, input, 1: raw PDM data from pad (asynchronous).
- pcm_o, output, OUT_W: signed PCM sample, held until next valid.
- pcm_valid_o, output, 1: one-cycle pulse when pcm_o updates.
- sat_o, output, 1: sticky flag, set when output saturates; cleared only by rst.

## Operation

- **Input capture.**
  - pdm_i passes through a 2-FF synchronizer.
  - mclk_i is registered once; an edge is detected by comparing the current and registered values, with edge type chosen by edge_sel.
  - On a detected edge with en=1, sample_stb pulses for 1 cycle, carrying the synchronized PDM bit.
- **Input mapping.** Bit 1 maps to +1, bit 0 to −1, sign-extended to ACC_W.
- **Integrators.**
  - ORDER cascaded integrators, each ACC_W wide, update only on sample_stb.
  - Arithmetic is two's-complement modulo 2^ACC_W; wrap-around is intended and must not be saturated.
- **Decimation counter.**
  - DECIM_LOG2-bit counter increments on sample_stb and wraps from R−1 to 0.
  - The sample_stb that takes the counter from R−1 to 0 raises dec_stb on the next cycle.
- **Combs.**
  - ORDER cascaded combs with differential delay 1, each ACC_W wide.
  - On dec_stb: each comb delay register loads its comb input, and the chain output is computed combinationally from the last integrator.
- **Scaling.**
  - Chain output is arithmetic-shifted right by ORDER*DECIM_LOG2 − (OUT_W−1) = 9.
  - The result is saturated to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
  - It is registered into pcm_o on dec_stb.
  - sat_o is set if clamping occurred.
- **Warm-up.**
  - A 3-bit counter suppresses pcm_valid_o for the first ORDER dec_stb events after rst; pcm_o still updates during warm-up.
  - Warm-up is not re-armed by en toggling.
- **Enable.** en=0 suppresses sample_stb and dec_stb. Integrators, combs, counters and pcm_o hold their values, and resume unchanged when en=1.

## Timing

- **Reset values.** After rst: pcm_o=0, pcm_valid_o=0, sat_o=0. Integrators, comb delays, decimation counter and warm-up counter are all 0; synchronizer and mclk registers are 0.
- **Latency.**
  - Edge on mclk_i to sample_stb: 1 cycle (registered compare).
  - pdm_i to sampled bit: 2 cycles of synchronizer.
  - sample_stb of the R-th sample to pcm_valid_o: 2 cycles.
- **Rates.**
  - Required: mclk_i period ≥ 4 clk cycles, so sample_stb events are ≥4 cycles apart.
  - Output rate: one word per R sample_stb events.
- **Simultaneous events.** rst dominates en and all strobes. A strobe in the same cycle as en falling is dropped.
- **Reset mid-frame.** All partial accumulation is discarded and warm-up restarts.

## Structure

- Shared package sonar_pkg holds ORDER, DECIM_LOG2, OUT_W, ACC_W and the shift constant; the IIR and MAF stages reuse OUT_W.
- One sub-module, pdm_sampler, contains the synchronizer, mclk edge detect and edge_sel logic, and outputs sample_stb plus the data bit.
- Integrator and comb chains are generate loops in the top module.

## Test plan

- **All-ones PDM.** mclk = clk/4, after rst. Required: the first valid appears at the 5th decimated output (4 suppressed); steady pcm_o = 32767; sat_o = 1.
- **All-zeros PDM.** Required: steady pcm_o = −32768 and sat_o stays 0, since the value is exact and no clamping occurs.
- **Repeating pattern 1,1,1,0.** Required: steady pcm_o = 16384. **Pattern 1,0.** Required: steady pcm_o = 0.
- **Valid spacing.** Required: pcm_valid_o pulses exactly every 256 clk cycles with mclk = clk/4, each pulse 1 cycle wide, and exactly 2 cycles after the 64th sample_stb.
- **Enable freeze.**
  - Stimulus: drop en for 100 cycles mid-frame with all-ones input.
  - Required: no strobes during the gap; the next valid is delayed by exactly the gap length; pcm_o is unchanged.
- **edge_sel and reset.**
  - edge_sel=1 with PDM toggling on mclk edges. Required: falling-edge samples are captured (all-ones result versus all-zeros for edge_sel=0).
  - rst mid-frame. Required: all outputs return to 0 and warm-up repeats.
